uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between N byte sources, for example the receive-echo path and the string/message generator.
- Picks one pending requester by round-robin and issues a one-cycle write strobe with its byte to the transmitter.
- Tracks the transmitter's idle flag through start and completion, then enforces a programmable inter-byte gap before the next grant.
- Sits between the control/sequencer logic and the uart_tx instance, on the UART clock.

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/uart_rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmitter arbiter: FSM state encoding and byte width.
package uart_arb_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ISSUE      = 3'd1,
      WAIT_START = 3'd2,
      WAIT_DONE  = 3'd3,
      GAP        = 3'd4
   } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the pointer, wrapping.
module uart_rr_pick #(
   parameter int N_REQ = 2,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic             any_req,
   output logic [PTR_W-1:0] winner
);

   assign any_req = |req;

   // Walk offsets from farthest to nearest so the nearest asserted request overwrites the rest.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (req[PTR_W'(idx)]) winner = PTR_W'(idx);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources,
// with start timeout and a programmable inter-byte gap.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ         = 2,
   parameter int GAP_CYCLES    = 16,
   parameter int START_TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [BYTE_W*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]        ack,
   output logic                    wrsig,
   output logic [BYTE_W-1:0]       txdata,
   input  logic                    tx_idle,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int TO_W  = $clog2(START_TIMEOUT + 1);

   arb_state_t        state, state_n;
   logic [PTR_W-1:0]  ptr, ptr_n;
   logic [PTR_W-1:0]  win, win_n;
   logic [GAP_W-1:0]  gap_cnt, gap_n;
   logic [TO_W-1:0]   timer, timer_n;
   logic [N_REQ-1:0]  ack_n;
   logic              wrsig_n, busy_n, timeout_n;
   logic [BYTE_W-1:0] txdata_n;

   logic              any_req;
   logic [PTR_W-1:0]  pick;
   logic [BYTE_W-1:0] req_bytes [N_REQ];

   always_comb begin
      for (int i = 0; i < N_REQ; i++) req_bytes[i] = req_data[BYTE_W*i +: BYTE_W];
   end

   uart_rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req     (req),
      .ptr     (ptr),
      .any_req (any_req),
      .winner  (pick)
   );

   // Next-state logic; strobe, ack and txdata are computed one state early so they register into ISSUE.
   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      win_n     = win;
      gap_n     = gap_cnt;
      timer_n   = timer;
      ack_n     = '0;
      wrsig_n   = 1'b0;
      timeout_n = 1'b0;
      txdata_n  = txdata;

      case (state)
         IDLE: begin
            if (any_req && tx_idle) begin
               state_n     = ISSUE;
               win_n       = pick;
               txdata_n    = req_bytes[pick];
               wrsig_n     = 1'b1;
               ack_n[pick] = 1'b1;
            end
         end
         ISSUE: begin
            state_n = WAIT_START;
            timer_n = '0;
            ptr_n   = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
         end
         WAIT_START: begin
            if (!tx_idle) begin
               state_n = WAIT_DONE;
            end else if (int'(timer) >= START_TIMEOUT - 1) begin
               // Transmitter never started: the byte is dropped, not retried.
               timeout_n = 1'b1;
               timer_n   = '0;
               gap_n     = '0;
               state_n   = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
               timer_n = timer + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (tx_idle) begin
               gap_n   = '0;
               state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (int'(gap_cnt) >= GAP_CYCLES - 1) state_n = IDLE;
            else                                 gap_n   = gap_cnt + 1'b1;
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         win         <= '0;
         gap_cnt     <= '0;
         timer       <= '0;
         ack         <= '0;
         wrsig       <= 1'b0;
         txdata      <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         ptr         <= ptr_n;
         win         <= win_n;
         gap_cnt     <= gap_n;
         timer       <= timer_n;
         ack         <= ack_n;
         wrsig       <= wrsig_n;
         txdata      <= txdata_n;
         busy        <= busy_n;
         timeout_err <= timeout_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: default build plus a GAP_CYCLES=0 build,
// driving tx_idle by hand as a simple transmitter model.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, ack;
   logic [15:0] req_data;
   logic        wrsig, tx_idle, busy, timeout_err;
   logic [7:0]  txdata;

   logic [1:0]  g_req, g_ack;
   logic [15:0] g_req_data;
   logic        g_wrsig, g_tx_idle, g_busy, g_timeout_err;
   logic [7:0]  g_txdata;

   int   compared   = 0;
   int   mismatched = 0;
   logic seen;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(2), .GAP_CYCLES(16), .START_TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
      .wrsig(wrsig), .txdata(txdata), .tx_idle(tx_idle), .busy(busy),
      .timeout_err(timeout_err)
   );

   uart_tx_arbiter #(.N_REQ(2), .GAP_CYCLES(0), .START_TIMEOUT(255)) dut_gap0 (
      .clk(clk), .rst(rst), .req(g_req), .req_data(g_req_data), .ack(g_ack),
      .wrsig(g_wrsig), .txdata(g_txdata), .tx_idle(g_tx_idle), .busy(g_busy),
      .timeout_err(g_timeout_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] r, input logic [15:0] d, input logic idle);
      req      = r;
      req_data = d;
      tx_idle  = idle;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkStrobe(input string tag, input logic [7:0] expData, input logic [1:0] expAck);
      checkOutput({tag, " wrsig"},  32'(wrsig),  32'd1);
      checkOutput({tag, " txdata"}, 32'(txdata), 32'(expData));
      checkOutput({tag, " ack"},    32'(ack),    32'(expAck));
   endtask

   // Called in the strobe cycle: transmitter starts after startDelay clocks, shifts, then goes idle.
   task automatic finishByte(input int startDelay, input int shiftClocks, input string tag);
      tick();
      checkOutput({tag, " strobe/ack one cycle"}, 32'({wrsig, ack}), 32'd0);
      repeat (startDelay) tick();
      tx_idle = 1'b0;
      seen    = 1'b0;
      repeat (shiftClocks) begin
         tick();
         seen = seen | wrsig | ~busy;
      end
      tx_idle = 1'b1;
      repeat (16) begin
         tick();
         seen = seen | wrsig | ~busy;
      end
      checkOutput({tag, " busy and quiet through byte+gap"}, 32'(seen), 32'd0);
      tick();
      checkOutput({tag, " busy drops after gap"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      applyStimulus(2'b00, 16'h0000, 1'b1);
      g_req      = 2'b00;
      g_req_data = 16'h0000;
      g_tx_idle  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset busy",        32'(busy),        32'd0);
      checkOutput("reset wrsig",       32'(wrsig),       32'd0);
      checkOutput("reset ack",         32'(ack),         32'd0);
      checkOutput("reset txdata",      32'(txdata),      32'd0);
      checkOutput("reset timeout_err", 32'(timeout_err), 32'd0);
      rst = 1'b0;

      // Single request
      applyStimulus(2'b01, 16'h0048, 1'b1);
      tick();
      checkStrobe("single", 8'h48, 2'b01);
      checkOutput("single busy", 32'(busy), 32'd1);
      applyStimulus(2'b00, 16'h0048, 1'b1);
      finishByte(2, 100, "single");

      // Contention from pointer 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(2'b11, 16'h4241, 1'b1);
      tick();
      checkStrobe("rr0", 8'h41, 2'b01);
      finishByte(0, 8, "rr0");
      tick();
      checkStrobe("rr1", 8'h42, 2'b10);
      finishByte(0, 8, "rr1");
      tick();
      checkStrobe("rr2", 8'h41, 2'b01);
      finishByte(0, 8, "rr2");
      tick();
      checkStrobe("rr3", 8'h42, 2'b10);
      applyStimulus(2'b00, 16'h4241, 1'b1);
      finishByte(0, 8, "rr3");

      // Start timeout: tx_idle never falls
      applyStimulus(2'b01, 16'h0055, 1'b1);
      tick();
      checkStrobe("timeout byte", 8'h55, 2'b01);
      applyStimulus(2'b00, 16'h0055, 1'b1);
      seen = 1'b0;
      repeat (255) begin
         tick();
         seen = seen | timeout_err;
      end
      checkOutput("timeout not early", 32'(seen), 32'd0);
      tick();
      checkOutput("timeout pulse at 256", 32'(timeout_err), 32'd1);
      tick();
      checkOutput("timeout one cycle", 32'(timeout_err), 32'd0);
      checkOutput("timeout gap busy", 32'(busy), 32'd1);
      repeat (14) tick();
      checkOutput("timeout gap end busy", 32'(busy), 32'd1);
      tick();
      checkOutput("timeout back to idle", 32'(busy), 32'd0);
      applyStimulus(2'b10, 16'h6600, 1'b1);
      tick();
      checkStrobe("after timeout", 8'h66, 2'b10);
      applyStimulus(2'b00, 16'h6600, 1'b1);
      finishByte(1, 4, "after timeout");

      // Transmitter busy externally when the request arrives
      applyStimulus(2'b10, 16'h7700, 1'b0);
      seen = 1'b0;
      repeat (6) begin
         tick();
         seen = seen | wrsig | busy;
      end
      checkOutput("held off while tx busy", 32'(seen), 32'd0);
      tx_idle = 1'b1;
      tick();
      checkStrobe("after tx idle", 8'h77, 2'b10);
      applyStimulus(2'b00, 16'h7700, 1'b1);
      finishByte(0, 4, "after tx idle");

      // Async reset during WAIT_DONE
      applyStimulus(2'b01, 16'h0099, 1'b1);
      tick();
      checkStrobe("pre-reset", 8'h99, 2'b01);
      applyStimulus(2'b00, 16'h0099, 1'b1);
      tick();
      tx_idle = 1'b0;
      repeat (3) tick();
      checkOutput("busy before reset", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async reset busy",   32'(busy),   32'd0);
      checkOutput("async reset wrsig",  32'(wrsig),  32'd0);
      checkOutput("async reset ack",    32'(ack),    32'd0);
      checkOutput("async reset txdata", 32'(txdata), 32'd0);
      tick();
      rst = 1'b0;
      applyStimulus(2'b11, 16'hA2A1, 1'b1);
      tick();
      checkStrobe("post-reset pointer", 8'hA1, 2'b01);
      applyStimulus(2'b00, 16'hA2A1, 1'b1);

      // GAP_CYCLES=0 build: back-to-back bytes from one requester
      g_req      = 2'b01;
      g_req_data = 16'h005A;
      g_tx_idle  = 1'b1;
      tick();
      checkOutput("gap0 first wrsig",  32'(g_wrsig),  32'd1);
      checkOutput("gap0 first txdata", 32'(g_txdata), 32'h5A);
      checkOutput("gap0 first ack",    32'(g_ack),    32'd1);
      g_req_data = 16'h005B;
      tick();
      g_tx_idle = 1'b0;
      repeat (4) tick();
      g_tx_idle = 1'b1;
      tick();
      checkOutput("gap0 idle wrsig", 32'(g_wrsig), 32'd0);
      checkOutput("gap0 idle busy",  32'(g_busy),  32'd0);
      tick();
      checkOutput("gap0 second wrsig",  32'(g_wrsig),  32'd1);
      checkOutput("gap0 second txdata", 32'(g_txdata), 32'h5B);
      checkOutput("gap0 second ack",    32'(g_ack),    32'd1);
      g_req = 2'b00;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
